branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side dynamic branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Looks up PCF combinationally and supplies the predicted next fetch PC.
- Trained from the execute stage using the resolved outcome (PCSrcE from the branch-resolution logic).
- Detects mispredictions and supplies the recovery PC to the PC mux and hazard unit.

Parameters:
- ENTRIES, 64, number of BTB entries; power of two, minimum 4.
- INDEX_W, log2(ENTRIES), derived localparam: index = PC[INDEX_W+1:2].
- TAG_W, 30-INDEX_W, derived localparam: tag = PC[31:INDEX_W+2].

Ports:
- CLK  input  1  core clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- PCF  input  32  fetch-stage PC.
- PredTakenF  output  1  prediction for PCF is taken.
- NextPCF  output  32  predicted next fetch PC.
- BranchE  input  1  execute-stage instruction is a conditional branch.
- JumpE  input  1  execute-stage instruction is jal/jalr.
- PCSrcE  input  1  resolved taken.
- PCE  input  32  execute-stage PC.
- PCTargetE  input  32  resolved target.
- PCPlus4E  input  32  PCE+4.
- PredTakenE  input  1  PredTakenF, pipelined to execute.
- PredTargetE  input  32  NextPCF, pipelined to execute.
- MispredictE  output  1  flush F/D and redirect.
- RecoverPCE  output  32  correct next PC when MispredictE=1.

Behaviour:
- Entry fields: valid, tag[TAG_W], target[32], ctr[2].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational, zero latency):
  - hit = valid && tag==PCF tag.
  - PredTakenF = hit && ctr[1].
  - NextPCF = PredTakenF ? target : PCF+4.
- Resolution (combinational, execute stage):
  - ctrl = BranchE|JumpE.
  - If ctrl: MispredictE = (PCSrcE != PredTakenE) || (PCSrcE && PredTakenE && PredTargetE != PCTargetE).
  - If !ctrl: MispredictE = PredTakenE (stale entry).
  - RecoverPCE = (ctrl && PCSrcE) ? PCTargetE : PCPlus4E.
- Update (registered at rising CLK, indexed by PCE):
  - ctrl, hit, taken: ctr saturating +1; target <= PCTargetE.
  - ctrl, hit, not taken: ctr saturating -1; target unchanged.
  - ctrl, miss, taken: allocate; valid=1, tag, target=PCTargetE. ctr=11 if JumpE, else 10. Overwrites any aliasing entry.
  - ctrl, miss, not taken: no write.
  - !ctrl && PredTakenE: clear valid of the PCE entry.
  - JumpE counters saturate at 11.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents; the new contents are visible from the next cycle. No bypass.
- Back-to-back updates to the same index apply in order, one per cycle.
- Reset (asynchronous, RST=0):
  - All valid, ctr, tag and target cleared immediately.
  - During reset PredTakenF=0 and NextPCF=PCF+4.
  - MispredictE and RecoverPCE stay combinational from inputs.
  - Reset asserted mid-update drops that update.
- Arithmetic: all PC sums are 32-bit modulo (0xFFFFFFFC+4 = 0x00000000).

Optional Feature:
- Macro: BRANCH_PREDICTOR_STATS_EN.
- When defined, adds outputs BranchCountE[31:0] and MispredictCountE[31:0]:
  - BranchCountE increments each cycle ctrl=1.
  - MispredictCountE increments each cycle MispredictE=1.
  - Both wrap modulo 2^32 and clear on reset.
- When not defined, the ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package bp_pkg:
  - Counter state constants SNT/WNT/WT/ST.
  - XLEN=32.
  - Next-state rule: counter_next(ctr, taken, jump).
- One sub-module, bp_ctr_update: purely combinational 2-bit saturating counter next-state logic, instantiated once on the update path.
- Table storage stays in the top level.

Test Plan:
- Reset, then PCF=0x00000040: PredTakenF=0, NextPCF=0x00000044, all entries invalid.
- Branch resolves at PCE=0x100, PCSrcE=1, PCTargetE=0x80, PredTakenE=0: MispredictE=1, RecoverPCE=0x80. Next cycle PCF=0x100: PredTakenF=1, NextPCF=0x80 (ctr=10).
- Same branch, PCSrcE=0, PredTakenE=1: MispredictE=1, RecoverPCE=0x104. Next cycle PCF=0x100: PredTakenF=0 (ctr=01).
- Alias: train taken at 0x100, then lookup 0x200 (same index, ENTRIES=64): PredTakenF=0. Lookup and update at index 0x100 in the same cycle: old value this cycle, new value the next.
- JumpE=1, PCE=0x300, PCTargetE=0x400: entry allocated with ctr=11. Later non-control at 0x300 with PredTakenE=1: MispredictE=1, RecoverPCE=0x304, entry invalidated. Targets changing on a taken hit also raise MispredictE.
- With BRANCH_PREDICTOR_STATS_EN: 5 branches with 2 mispredicts give BranchCountE=5 and MispredictCountE=2. Preloaded 0xFFFFFFFF wraps to 0. Async reset clears both counters mid-run.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the BTB branch predictor: counter encoding, data width
// and the 2-bit saturating counter next-state rule.
package bp_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Jumps are always taken, so a taken jump pins its counter at strong-taken.
    function automatic ctr_e counter_next(input ctr_e ctr, input logic taken, input logic jump);
        ctr_e nxt;
        nxt = ctr;
        if (taken) begin
            if (jump) begin
                nxt = ST;
            end else begin
                case (ctr)
                    SNT:     nxt = WNT;
                    WNT:     nxt = WT;
                    default: nxt = ST;
                endcase
            end
        end else begin
            case (ctr)
                ST:      nxt = WT;
                WT:      nxt = WNT;
                default: nxt = SNT;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_ctr_update.sv
// Combinational next counter value for the entry being trained: step on a hit,
// initial strength on allocation.
module bp_ctr_update
    import bp_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    input  logic       i_jump,
    input  logic       i_hit,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_hit) begin
            o_ctr = counter_next(ctr_e'(i_ctr), i_taken, i_jump);
        end else begin
            o_ctr = i_jump ? ST : WT;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB predictor: zero-latency lookup on PCF, execute-stage training and misprediction recovery.
// Optional BRANCH_PREDICTOR_STATS_EN adds wrapping branch/mispredict counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] NextPCF,
    input  logic        BranchE,
    input  logic        JumpE,
    input  logic        PCSrcE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] PCPlus4E,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] RecoverPCE
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0] BranchCountE,
    output logic [31:0] MispredictCountE
`endif
);

    localparam int INDEX_W = $clog2(ENTRIES);
    localparam int TAG_W   = XLEN - 2 - INDEX_W;

    logic               r_valid  [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [XLEN-1:0]    r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    logic [INDEX_W-1:0] w_idx_f;
    logic [TAG_W-1:0]   w_tag_f;
    logic               w_hit_f;
    logic [INDEX_W-1:0] w_idx_e;
    logic [TAG_W-1:0]   w_tag_e;
    logic               w_hit_e;
    logic               w_ctrl;
    logic [1:0]         w_ctr_next;
    logic               w_unused_lsbs;

    assign w_unused_lsbs = ^{PCF[1:0], PCE[1:0]};

    assign w_idx_f    = PCF[INDEX_W+1:2];
    assign w_tag_f    = PCF[XLEN-1:INDEX_W+2];
    assign w_hit_f    = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
    assign PredTakenF = w_hit_f && r_ctr[w_idx_f][1];
    assign NextPCF    = PredTakenF ? r_target[w_idx_f] : PCF + 32'd4;

    assign w_ctrl     = BranchE | JumpE;
    assign RecoverPCE = (w_ctrl && PCSrcE) ? PCTargetE : PCPlus4E;

    // A predicted-taken non-control instruction means the entry it hit is stale.
    always_comb begin
        MispredictE = PredTakenE;
        if (w_ctrl) begin
            MispredictE = (PCSrcE != PredTakenE) ||
                          (PCSrcE && PredTakenE && (PredTargetE != PCTargetE));
        end
    end

    assign w_idx_e = PCE[INDEX_W+1:2];
    assign w_tag_e = PCE[XLEN-1:INDEX_W+2];
    assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

    bp_ctr_update u_ctr_update (
        .i_ctr   (r_ctr[w_idx_e]),
        .i_taken (PCSrcE),
        .i_jump  (JumpE),
        .i_hit   (w_hit_e),
        .o_ctr   (w_ctr_next)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b00;
            end
        end else if (w_ctrl) begin
            if (w_hit_e) begin
                r_ctr[w_idx_e] <= w_ctr_next;
                if (PCSrcE) begin
                    r_target[w_idx_e] <= PCTargetE;
                end
            end else if (PCSrcE) begin
                r_valid[w_idx_e]  <= 1'b1;
                r_tag[w_idx_e]    <= w_tag_e;
                r_target[w_idx_e] <= PCTargetE;
                r_ctr[w_idx_e]    <= w_ctr_next;
            end
        end else if (PredTakenE) begin
            r_valid[w_idx_e] <= 1'b0;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispredict_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_ctrl) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (MispredictE) begin
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
        end
    end

    assign BranchCountE     = r_branch_cnt;
    assign MispredictCountE = r_mispredict_cnt;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor against a table-level behavioural model.
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] NextPCF;
    logic        BranchE, JumpE, PCSrcE, PredTakenE;
    logic [31:0] PCE, PCTargetE, PCPlus4E, PredTargetE;
    logic        MispredictE;
    logic [31:0] RecoverPCE;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] BranchCountE;
    logic [31:0] MispredictCountE;
`endif

    always #5 CLK = ~CLK;

    branch_predictor #(.ENTRIES(64)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PCF         (PCF),
        .PredTakenF  (PredTakenF),
        .NextPCF     (NextPCF),
        .BranchE     (BranchE),
        .JumpE       (JumpE),
        .PCSrcE      (PCSrcE),
        .PCE         (PCE),
        .PCTargetE   (PCTargetE),
        .PCPlus4E    (PCPlus4E),
        .PredTakenE  (PredTakenE),
        .PredTargetE (PredTargetE),
        .MispredictE (MispredictE),
        .RecoverPCE  (RecoverPCE)
`ifdef BRANCH_PREDICTOR_STATS_EN
        ,
        .BranchCountE     (BranchCountE),
        .MispredictCountE (MispredictCountE)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference table: 64 entries, index = word address mod 64, tag = PC / 256.
    bit          m_v   [64];
    int unsigned m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_ctr [64];
    int unsigned m_bcnt = 0;
    int unsigned m_mcnt = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> 8;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            m_v[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 0;
        end
        m_bcnt = 0;
        m_mcnt = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] pcf, input bit br, input bit j, input bit src,
                        input logic [31:0] pce, input logic [31:0] tgt,
                        input bit pt, input logic [31:0] ptg);
        bit          ctrl, e_misp;
        logic [31:0] e_rec;
        int          i;
        @(negedge CLK);
        PCF = pcf; BranchE = br; JumpE = j; PCSrcE = src; PCE = pce;
        PCTargetE = tgt; PCPlus4E = pce + 32'd4; PredTakenE = pt; PredTargetE = ptg;
        #1;
        ctrl   = br || j;
        e_misp = ctrl ? ((src != pt) || (src && pt && (ptg != tgt))) : pt;
        e_rec  = (ctrl && src) ? tgt : pce + 32'd4;
        chk("pred_taken_f", {31'd0, PredTakenF}, {31'd0, m_pred(pcf)});
        chk("next_pc_f", NextPCF, m_next(pcf));
        chk("mispredict_e", {31'd0, MispredictE}, {31'd0, e_misp});
        chk("recover_pc_e", RecoverPCE, e_rec);
        i = idx_of(pce);
        if (ctrl) begin
            if (m_hit(pce)) begin
                if (src) begin
                    m_ctr[i] = j ? 3 : ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3);
                    m_tgt[i] = tgt;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (src) begin
                m_v[i] = 1'b1; m_tag[i] = tag_of(pce); m_tgt[i] = tgt; m_ctr[i] = j ? 3 : 2;
            end
        end else if (pt) begin
            m_v[i] = 1'b0;
        end
        if (ctrl) m_bcnt++;
        if (e_misp) m_mcnt++;
    endtask

    task automatic idle(input logic [31:0] pcf);
        step(pcf, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
        return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
    endfunction

    initial begin
        logic [31:0] pcf, pce, tgt, ptg;
        bit          br, j, src, pt;
        int          kind;

        model_clear();
        RST = 1'b0; PCF = 32'h40; BranchE = 0; JumpE = 0; PCSrcE = 0; PCE = 0;
        PCTargetE = 0; PCPlus4E = 0; PredTakenE = 0; PredTargetE = 0;
        #3;
        chk("reset_pred", {31'd0, PredTakenF}, 32'd0);
        chk("reset_next", NextPCF, 32'h44);
        #1 RST = 1'b1;

        // Allocate on taken miss; lookup of the same index this cycle still sees the old entry.
        step(32'h100, 1, 0, 1, 32'h100, 32'h80, 0, 32'h104);
        chk("alloc_misp", {31'd0, MispredictE}, 32'd1);
        chk("alloc_rec", RecoverPCE, 32'h80);
        chk("same_cycle_old", {31'd0, PredTakenF}, 32'd0);
        idle(32'h100);
        chk("trained_pred", {31'd0, PredTakenF}, 32'd1);
        chk("trained_next", NextPCF, 32'h80);
        step(32'h200, 1, 0, 0, 32'h100, 32'h80, 1, 32'h80);
        chk("nt_rec", RecoverPCE, 32'h104);
        chk("alias_miss", {31'd0, PredTakenF}, 32'd0);
        idle(32'h100);
        chk("weak_nt_pred", {31'd0, PredTakenF}, 32'd0);

        // Jump allocation at strong-taken, then invalidation by a stale non-control hit.
        step(32'h300, 0, 1, 1, 32'h300, 32'h400, 0, 32'h304);
        step(32'h300, 0, 0, 0, 32'h300, 32'h0, 1, 32'h400);
        chk("jump_next", NextPCF, 32'h400);
        chk("stale_misp", {31'd0, MispredictE}, 32'd1);
        chk("stale_rec", RecoverPCE, 32'h304);
        idle(32'h300);
        chk("invalidated", {31'd0, PredTakenF}, 32'd0);

        // Taken hit with a changed target.
        step(32'h100, 1, 0, 1, 32'h100, 32'h80, 0, 32'h104);
        step(32'h100, 1, 0, 1, 32'h100, 32'h90, 1, 32'h80);
        chk("tgt_change_misp", {31'd0, MispredictE}, 32'd1);
        idle(32'h100);
        chk("tgt_updated", NextPCF, 32'h90);

        step(32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 0, 32'h0);
        chk("wrap_next", NextPCF, 32'h0);
        chk("wrap_rec", RecoverPCE, 32'h0);

        for (int n = 0; n < 400; n++) begin
            pcf  = rand_pc();
            pce  = rand_pc();
            kind = $urandom_range(0, 9);
            br   = (kind < 6);
            j    = (kind == 6);
            src  = j ? 1'b1 : 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       tgt = 32'h80;
                1:       tgt = 32'h90;
                2:       tgt = 32'h1000;
                default: tgt = $urandom & 32'hFFFF_FFFC;
            endcase
            pt  = m_pred(pce) ^ ($urandom_range(0, 4) == 0);
            ptg = m_next(pce);
            if ($urandom_range(0, 7) == 0) ptg = $urandom & 32'hFFFF_FFFC;
            step(pcf, br, j, src, pce, tgt, pt, ptg);
        end

`ifdef BRANCH_PREDICTOR_STATS_EN
        idle(32'h0);
        chk("branch_count", BranchCountE, m_bcnt);
        chk("mispredict_count", MispredictCountE, m_mcnt);
`endif

        // Asynchronous reset mid-update: table clears at once and the pending update is dropped.
        step(32'h500, 1, 0, 1, 32'h500, 32'h600, 0, 32'h504);
        @(negedge CLK);
        PCF = 32'h500; BranchE = 1; JumpE = 0; PCSrcE = 1; PCE = 32'h700;
        PCTargetE = 32'h800; PCPlus4E = 32'h704; PredTakenE = 0; PredTargetE = 32'h704;
        #1 RST = 1'b0;
        #1;
        chk("rst_pred", {31'd0, PredTakenF}, 32'd0);
        chk("rst_next", NextPCF, 32'h504);
        chk("rst_misp_comb", {31'd0, MispredictE}, 32'd1);
        chk("rst_rec_comb", RecoverPCE, 32'h800);
        model_clear();
`ifdef BRANCH_PREDICTOR_STATS_EN
        chk("rst_branch_count", BranchCountE, 32'd0);
        chk("rst_mispredict_count", MispredictCountE, 32'd0);
`endif
        @(negedge CLK);
        BranchE = 0; PCSrcE = 0;
        RST = 1'b1;
        idle(32'h700);
        chk("dropped_update", {31'd0, PredTakenF}, 32'd0);
        idle(32'h500);
        chk("cleared_entry", {31'd0, PredTakenF}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
